// File: rtl/vending_credit_fsm_if.sv
// ---------------------------------------------------------------------------
// vending_credit_fsm_if
// Bundles the coin/vend request inputs and the credit/dispense/change outputs
// of the vending credit controller. Signal prefixes are from the controller's
// point of view (i_ = into the controller, o_ = out of it).
//
//   i_coin_valid   : COIN is sampled on this cycle's rising edge
//   i_coin[1:0]    : 01 nickel, 10 dime, 11 quarter, 00 invalid
//   i_select       : vend request (level)
//   i_cancel       : refund request (level)
//   o_credit[3:0]  : current credit in 5-cent units
//   o_dispense     : one-cycle product release pulse
//   o_change_valid : one-cycle qualifier for o_change
//   o_change[3:0]  : units to return, 0 when not qualified
//   o_coin_reject  : one-cycle pulse for a refused coin
//   o_busy         : high while vending or refunding
//
// Modports: master = coin mechanism / front panel, slave = controller.
// ---------------------------------------------------------------------------
interface vending_credit_fsm_if;
    logic       i_coin_valid;
    logic [1:0] i_coin;
    logic       i_select;
    logic       i_cancel;
    logic [3:0] o_credit;
    logic       o_dispense;
    logic       o_change_valid;
    logic [3:0] o_change;
    logic       o_coin_reject;
    logic       o_busy;

    modport master (
        output i_coin_valid, i_coin, i_select, i_cancel,
        input  o_credit, o_dispense, o_change_valid, o_change, o_coin_reject, o_busy
    );

    modport slave (
        input  i_coin_valid, i_coin, i_select, i_cancel,
        output o_credit, o_dispense, o_change_valid, o_change, o_coin_reject, o_busy
    );
endinterface

// File: rtl/vending_credit_fsm.sv
// ---------------------------------------------------------------------------
// vending_credit_fsm
// Coin-acceptance and vend-control state machine. Accumulates coins into a
// 4-bit credit, vends when credit reaches PRICE and SELECT is requested, and
// refunds the credit on CANCEL. All outputs are registered; o_credit drives
// the downstream display state register.
//
// Parameters:
//   PRICE   : product price in 5-cent units, legal range 1..15
// Ports:
//   i_clk   : clock, rising edge active
//   i_rst_n : asynchronous active-low reset (release is synchronised upstream)
//   bus     : vending_credit_fsm_if.slave (coin/request in, credit/pulses out)
// ---------------------------------------------------------------------------
module vending_credit_fsm #(
    parameter int unsigned PRICE = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    vending_credit_fsm_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_READY,
        S_VEND,
        S_REFUND
    } state_t;

    // PRICE outside 1..15 is a configuration error; it is truncated here.
    localparam logic [3:0] LP_PRICE = 4'(PRICE);

    state_t     r_state;
    logic [3:0] r_credit;
    logic       r_dispense;
    logic       r_change_valid;
    logic [3:0] r_change;
    logic       r_coin_reject;
    logic       r_busy;

    state_t     w_next_state;
    logic [3:0] w_next_credit;
    logic       w_next_dispense;
    logic       w_next_change_valid;
    logic [3:0] w_next_change;
    logic       w_next_coin_reject;
    logic [3:0] w_coin_value;
    logic [4:0] w_sum;
    logic       w_cancel_acts;
    logic       w_select_acts;

    // Credit level decides which waiting state we settle in.
    function automatic state_t classify(input logic [3:0] credit);
        if (credit == 4'd0)
            return S_IDLE;
        else if (credit < LP_PRICE)
            return S_CREDIT;
        else
            return S_READY;
    endfunction

    // Coin code to value in 5-cent units; invalid code is worth nothing.
    always_comb begin
        w_coin_value = 4'd0;
        case (bus.i_coin)
            2'b01:   w_coin_value = 4'd1;
            2'b10:   w_coin_value = 4'd2;
            2'b11:   w_coin_value = 4'd5;
            default: w_coin_value = 4'd0;
        endcase
    end

    // One extra bit so the <= 15 acceptance test sees a would-be overflow.
    assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_value};

    // CANCEL beats SELECT, and either one blocks a coin in the same cycle.
    assign w_cancel_acts = bus.i_cancel && ((r_state == S_CREDIT) || (r_state == S_READY));
    assign w_select_acts = bus.i_select && (r_state == S_READY) && !w_cancel_acts;

    // Next-state and next-output logic. Pulses default low so none can
    // repeat on its own; vend/refund always fall back to idle after one cycle.
    always_comb begin
        w_next_state        = r_state;
        w_next_credit       = r_credit;
        w_next_dispense     = 1'b0;
        w_next_change_valid = 1'b0;
        w_next_change       = 4'd0;
        w_next_coin_reject  = 1'b0;

        case (r_state)
            S_IDLE, S_CREDIT, S_READY: begin
                if (w_cancel_acts) begin
                    w_next_state        = S_REFUND;
                    w_next_change_valid = 1'b1;
                    w_next_change       = r_credit;
                    w_next_credit       = 4'd0;
                    w_next_coin_reject  = bus.i_coin_valid;
                end else if (w_select_acts) begin
                    w_next_state        = S_VEND;
                    w_next_dispense     = 1'b1;
                    w_next_change_valid = 1'b1;
                    w_next_change       = r_credit - LP_PRICE;
                    w_next_credit       = 4'd0;
                    w_next_coin_reject  = bus.i_coin_valid;
                end else begin
                    if (bus.i_coin_valid) begin
                        if ((bus.i_coin != 2'b00) && (w_sum <= 5'd15))
                            w_next_credit = w_sum[3:0];
                        else
                            w_next_coin_reject = 1'b1;
                    end
                    w_next_state = classify(w_next_credit);
                end
            end
            S_VEND, S_REFUND: begin
                w_next_state       = S_IDLE;
                w_next_credit      = 4'd0;
                w_next_coin_reject = bus.i_coin_valid;
            end
            default: begin
                w_next_state  = S_IDLE;
                w_next_credit = 4'd0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately,
    // which also aborts an in-flight vend or refund pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_credit       <= 4'd0;
            r_dispense     <= 1'b0;
            r_change_valid <= 1'b0;
            r_change       <= 4'd0;
            r_coin_reject  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_credit       <= w_next_credit;
            r_dispense     <= w_next_dispense;
            r_change_valid <= w_next_change_valid;
            r_change       <= w_next_change;
            r_coin_reject  <= w_next_coin_reject;
            r_busy         <= (w_next_state == S_VEND) || (w_next_state == S_REFUND);
        end
    end

    assign bus.o_credit       = r_credit;
    assign bus.o_dispense     = r_dispense;
    assign bus.o_change_valid = r_change_valid;
    assign bus.o_change       = r_change;
    assign bus.o_coin_reject  = r_coin_reject;
    assign bus.o_busy         = r_busy;

endmodule

// File: tb/tb_vending_credit_fsm.sv
// ---------------------------------------------------------------------------
// tb_vending_credit_fsm
// Directed bench for vending_credit_fsm with PRICE = 3. Each step drives one
// cycle of inputs, then compares all outputs a little after the clock edge
// against a hand-computed vector.
// Expected vector layout: {credit[3:0], dispense, change_valid, change[3:0],
//                          coin_reject, busy}
// ---------------------------------------------------------------------------
module tb_vending_credit_fsm;

    localparam logic [1:0] NONE    = 2'b00;
    localparam logic [1:0] NICKEL  = 2'b01;
    localparam logic [1:0] DIME    = 2'b10;
    localparam logic [1:0] QUARTER = 2'b11;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    vending_credit_fsm_if vif ();

    vending_credit_fsm #(.PRICE(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (vif.slave)
    );

    // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack expected fields in the same order as the observed vector.
    function automatic logic [11:0] ex(input logic [3:0] credit, input logic disp,
                                       input logic cv, input logic [3:0] chg,
                                       input logic rej, input logic busy);
        return {credit, disp, cv, chg, rej, busy};
    endfunction

    // Drive one cycle of inputs, clock it in, then return inputs to idle.
    task automatic applyStimulus(input logic coinValid, input logic [1:0] coin,
                                 input logic sel, input logic cancel);
        vif.i_coin_valid = coinValid;
        vif.i_coin       = coin;
        vif.i_select     = sel;
        vif.i_cancel     = cancel;
        @(posedge clk);
        #1;
        vif.i_coin_valid = 1'b0;
        vif.i_coin       = NONE;
        vif.i_select     = 1'b0;
        vif.i_cancel     = 1'b0;
    endtask

    // Compare every output at once against the expected vector.
    task automatic checkOutput(input string tag, input logic [11:0] expected);
        logic [11:0] observed;
        observed = {vif.o_credit, vif.o_dispense, vif.o_change_valid,
                    vif.o_change, vif.o_coin_reject, vif.o_busy};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%03h expected=%03h", tag, observed, expected);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        vif.i_coin_valid = 1'b0;
        vif.i_coin       = NONE;
        vif.i_select     = 1'b0;
        vif.i_cancel     = 1'b0;

        #2;
        checkOutput("reset_state", ex(4'd0, 0, 0, 4'd0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        applyStimulus(0, NONE, 0, 0);
        checkOutput("idle_after_reset", ex(4'd0, 0, 0, 4'd0, 0, 0));

        // Dime then nickel reaches the price, exact-change vend.
        applyStimulus(1, DIME, 0, 0);
        checkOutput("dime_credit2", ex(4'd2, 0, 0, 4'd0, 0, 0));
        applyStimulus(1, NICKEL, 0, 0);
        checkOutput("nickel_credit3", ex(4'd3, 0, 0, 4'd0, 0, 0));
        applyStimulus(0, NONE, 1, 0);
        checkOutput("vend_exact", ex(4'd0, 1, 1, 4'd0, 0, 1));
        applyStimulus(0, NONE, 0, 0);
        checkOutput("after_vend_exact", ex(4'd0, 0, 0, 4'd0, 0, 0));

        // Quarter then vend returns two units of change.
        applyStimulus(1, QUARTER, 0, 0);
        checkOutput("quarter_credit5", ex(4'd5, 0, 0, 4'd0, 0, 0));
        applyStimulus(0, NONE, 1, 0);
        checkOutput("vend_change2", ex(4'd0, 1, 1, 4'd2, 0, 1));
        applyStimulus(0, NONE, 0, 0);
        checkOutput("after_vend_change2", ex(4'd0, 0, 0, 4'd0, 0, 0));

        // Fill to 15, then overflow and invalid coins are refused.
        applyStimulus(1, QUARTER, 0, 0);
        checkOutput("q1_credit5", ex(4'd5, 0, 0, 4'd0, 0, 0));
        applyStimulus(1, QUARTER, 0, 0);
        checkOutput("q2_credit10", ex(4'd10, 0, 0, 4'd0, 0, 0));
        applyStimulus(1, QUARTER, 0, 0);
        checkOutput("q3_credit15", ex(4'd15, 0, 0, 4'd0, 0, 0));
        applyStimulus(1, QUARTER, 0, 0);
        checkOutput("q4_reject", ex(4'd15, 0, 0, 4'd0, 1, 0));
        applyStimulus(0, NONE, 0, 0);
        checkOutput("reject_one_cycle", ex(4'd15, 0, 0, 4'd0, 0, 0));
        applyStimulus(1, NONE, 0, 0);
        checkOutput("coin00_reject", ex(4'd15, 0, 0, 4'd0, 1, 0));
        applyStimulus(1, NICKEL, 0, 0);
        checkOutput("nickel_at15_reject", ex(4'd15, 0, 0, 4'd0, 1, 0));
        applyStimulus(0, NONE, 0, 1);
        checkOutput("refund15", ex(4'd0, 0, 1, 4'd15, 0, 1));
        applyStimulus(0, NONE, 0, 0);
        checkOutput("after_refund15", ex(4'd0, 0, 0, 4'd0, 0, 0));

        // Below price: SELECT ignored, CANCEL refunds.
        applyStimulus(1, DIME, 0, 0);
        checkOutput("dime_credit2_b", ex(4'd2, 0, 0, 4'd0, 0, 0));
        applyStimulus(0, NONE, 1, 0);
        checkOutput("select_below_price", ex(4'd2, 0, 0, 4'd0, 0, 0));
        applyStimulus(0, NONE, 0, 1);
        checkOutput("refund2", ex(4'd0, 0, 1, 4'd2, 0, 1));
        applyStimulus(0, NONE, 0, 0);
        checkOutput("after_refund2", ex(4'd0, 0, 0, 4'd0, 0, 0));

        // Requests in IDLE do nothing.
        applyStimulus(0, NONE, 0, 1);
        checkOutput("cancel_in_idle", ex(4'd0, 0, 0, 4'd0, 0, 0));
        applyStimulus(0, NONE, 1, 0);
        checkOutput("select_in_idle", ex(4'd0, 0, 0, 4'd0, 0, 0));

        // Credit 4 with cancel, select and dime together: cancel wins.
        applyStimulus(1, DIME, 0, 0);
        checkOutput("dime_a", ex(4'd2, 0, 0, 4'd0, 0, 0));
        applyStimulus(1, DIME, 0, 0);
        checkOutput("dime_b_credit4", ex(4'd4, 0, 0, 4'd0, 0, 0));
        applyStimulus(1, DIME, 1, 1);
        checkOutput("priority_refund4", ex(4'd0, 0, 1, 4'd4, 1, 1));
        applyStimulus(0, NONE, 0, 0);
        checkOutput("after_priority", ex(4'd0, 0, 0, 4'd0, 0, 0));

        // Select wins over a coin in READY.
        applyStimulus(1, NICKEL, 0, 0);
        applyStimulus(1, DIME, 0, 0);
        checkOutput("credit3_again", ex(4'd3, 0, 0, 4'd0, 0, 0));
        applyStimulus(1, NICKEL, 1, 0);
        checkOutput("select_over_coin", ex(4'd0, 1, 1, 4'd0, 1, 1));

        // Coin during VEND rejected; coin right after is accepted.
        applyStimulus(1, NICKEL, 0, 0);
        checkOutput("coin_in_vend_reject", ex(4'd0, 0, 0, 4'd0, 1, 0));
        applyStimulus(1, NICKEL, 0, 0);
        checkOutput("coin_after_vend", ex(4'd1, 0, 0, 4'd0, 0, 0));
        applyStimulus(0, NONE, 0, 1);
        checkOutput("refund1", ex(4'd0, 0, 1, 4'd1, 0, 1));
        applyStimulus(1, DIME, 1, 1);
        checkOutput("coin_in_refund_reject", ex(4'd0, 0, 0, 4'd0, 1, 0));

        // Reset between edges during VEND clears outputs at once.
        applyStimulus(1, QUARTER, 0, 0);
        checkOutput("quarter_before_abort", ex(4'd5, 0, 0, 4'd0, 0, 0));
        applyStimulus(0, NONE, 1, 0);
        checkOutput("vend_before_abort", ex(4'd0, 1, 1, 4'd2, 0, 1));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_abort", ex(4'd0, 0, 0, 4'd0, 0, 0));
        @(posedge clk);
        #1;
        checkOutput("held_in_reset", ex(4'd0, 0, 0, 4'd0, 0, 0));
        rst_n = 1'b1;
        applyStimulus(1, NICKEL, 0, 0);
        checkOutput("nickel_after_reset", ex(4'd1, 0, 0, 4'd0, 0, 0));
        applyStimulus(0, NONE, 0, 1);
        checkOutput("refund_after_reset", ex(4'd0, 0, 1, 4'd1, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
